rfft_4pt256: RTL and testbench

Radix-2 in-place FFT engine for a 256-point complex FFT, four samples wide. It holds four 64-entry data banks. Each cycle it reads one word per bank and performs two butterflies with a shared twiddle factor. Results are routed back into the banks. The sequencer (stage/cycle counting, addresses, mux selects, twiddle lookup) is external; this block is the datapath plus bank storage only.

---
 rtl/rfft_4pt256_pkg.sv | 38 +++
 rtl/rfft_4pt256_if.sv | 40 ++++
 rtl/rfft_4pt256_bfly.sv | 45 ++++
 rtl/rfft_4pt256.sv | 131 +++++++++++++
 tb/tb_rfft_4pt256.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rfft_4pt256_pkg.sv
// Shared constants, the packed complex sample type and per-half complex
// add/sub helpers for the four-wide radix-2 FFT datapath.
package rfft_4pt256_pkg;

  localparam int DATA_BIT   = 16;
  localparam int ADDR_BIT   = 6;
  localparam int N          = 256;
  localparam int MEM_HEIGHT = N / 4;
  localparam int NUM_BANK   = 4;
  localparam int HALF_BIT   = DATA_BIT / 2;
  localparam int TW_SHIFT   = DATA_BIT - 2;

  // Twiddle value representing 1.0 in Q2.(DATA_BIT-2).
  localparam logic [DATA_BIT-1:0] TW_ONE = DATA_BIT'(32'd1 << TW_SHIFT);

  // One packed complex sample: real half in the upper bits.
  typedef struct packed {
    logic signed [HALF_BIT-1:0] re;
    logic signed [HALF_BIT-1:0] im;
  } cplx_t;

  // Per-half sum; each half wraps modulo 2^HALF_BIT.
  function automatic cplx_t cplx_add(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  // Per-half difference; each half wraps modulo 2^HALF_BIT.
  function automatic cplx_t cplx_sub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

endpackage

// File: rtl/rfft_4pt256_if.sv
// Data/control bundle between the external sequencer and the FFT datapath.
interface rfft_4pt256_if;
  import rfft_4pt256_pkg::*;

  logic [DATA_BIT-1:0]            in0, in1, in2, in3;
  logic [DATA_BIT-1:0]            mem0_i, mem1_i, mem2_i, mem3_i;
  logic [DATA_BIT-1:0]            mem0, mem1, mem2, mem3;
  logic                           m0;
  logic                           m11;
  logic [1:0]                     m12;
  logic [1:0]                     m13;
  logic                           m14;
  logic                           m21, m22, m23, m24;
  logic                           en;
  logic                           we;
  logic                           re;
  logic [DATA_BIT-1:0]            w_r, w_i;
  logic                           bypass_en;
  logic [NUM_BANK*ADDR_BIT-1:0]   addr_read;
  logic [NUM_BANK*ADDR_BIT-1:0]   addr_write;

  // Sequencer side: drives controls and load data, observes bank traffic.
  modport master (
    output in0, in1, in2, in3,
    output m0, m11, m12, m13, m14, m21, m22, m23, m24,
    output en, we, re, w_r, w_i, bypass_en, addr_read, addr_write,
    input  mem0_i, mem1_i, mem2_i, mem3_i,
    input  mem0, mem1, mem2, mem3
  );

  // Datapath side.
  modport slave (
    input  in0, in1, in2, in3,
    input  m0, m11, m12, m13, m14, m21, m22, m23, m24,
    input  en, we, re, w_r, w_i, bypass_en, addr_read, addr_write,
    output mem0_i, mem1_i, mem2_i, mem3_i,
    output mem0, mem1, mem2, mem3
  );

endinterface

// File: rtl/rfft_4pt256_bfly.sv
// Radix-2 butterfly: y_sum = a + b, y_diff = (a - b) * W, or the raw
// difference when bypass_en is set. Purely combinational.
module rfft_bfly
  import rfft_4pt256_pkg::*;
(
  input  cplx_t                      a,
  input  cplx_t                      b,
  input  logic signed [DATA_BIT-1:0] w_r,
  input  logic signed [DATA_BIT-1:0] w_i,
  input  logic                       bypass_en,
  output cplx_t                      y_sum,
  output cplx_t                      y_diff
);

  // Wide enough for the exact sum of two HALF_BIT x DATA_BIT products.
  localparam int PROD_BIT = HALF_BIT + DATA_BIT + 1;

  cplx_t                      diff_s;
  logic signed [PROD_BIT-1:0] dr_x_s, di_x_s, wr_x_s, wi_x_s;
  logic signed [PROD_BIT-1:0] prod_re_s, prod_im_s;

  assign y_sum  = cplx_add(a, b);
  assign diff_s = cplx_sub(a, b);

  assign dr_x_s = {{(PROD_BIT-HALF_BIT){diff_s.re[HALF_BIT-1]}}, diff_s.re};
  assign di_x_s = {{(PROD_BIT-HALF_BIT){diff_s.im[HALF_BIT-1]}}, diff_s.im};
  assign wr_x_s = {{(PROD_BIT-DATA_BIT){w_r[DATA_BIT-1]}}, w_r};
  assign wi_x_s = {{(PROD_BIT-DATA_BIT){w_i[DATA_BIT-1]}}, w_i};

  // Full-precision complex product; no rounding, floor on the shift below.
  assign prod_re_s = (dr_x_s * wr_x_s) - (di_x_s * wi_x_s);
  assign prod_im_s = (dr_x_s * wi_x_s) + (di_x_s * wr_x_s);

  // Select raw difference or twiddled difference truncated back to a half.
  always_comb begin
    y_diff = diff_s;
    if (bypass_en) begin
      y_diff = diff_s;
    end else begin
      y_diff.re = HALF_BIT'(prod_re_s >>> TW_SHIFT);
      y_diff.im = HALF_BIT'(prod_im_s >>> TW_SHIFT);
    end
  end

endmodule

// File: rtl/rfft_4pt256.sv
// Four-bank in-place FFT datapath: registered bank reads, operand muxes,
// two shared-twiddle butterflies and write-back routing. Addresses and
// selects come from an external sequencer.
module rfft_4pt256
  import rfft_4pt256_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rfft_4pt256_if.slave   bus
);

  logic [DATA_BIT-1:0] bank_r  [NUM_BANK][MEM_HEIGHT];
  logic [DATA_BIT-1:0] rd_r    [NUM_BANK];
  logic [DATA_BIT-1:0] wr_s    [NUM_BANK];
  logic [DATA_BIT-1:0] load_s  [NUM_BANK];

  cplx_t x0_s, x1_s, x2_s, x3_s;
  cplx_t y0_s, y1_s, y2_s, y3_s;

  assign load_s[0] = bus.in0;
  assign load_s[1] = bus.in1;
  assign load_s[2] = bus.in2;
  assign load_s[3] = bus.in3;

  assign bus.mem0 = rd_r[0];
  assign bus.mem1 = rd_r[1];
  assign bus.mem2 = rd_r[2];
  assign bus.mem3 = rd_r[3];

  assign bus.mem0_i = wr_s[0];
  assign bus.mem1_i = wr_s[1];
  assign bus.mem2_i = wr_s[2];
  assign bus.mem3_i = wr_s[3];

  // Bank storage writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (bus.en && bus.we) begin
      for (int k = 0; k < NUM_BANK; k++) begin
        bank_r[k][bus.addr_write[k*ADDR_BIT +: ADDR_BIT]] <= wr_s[k];
      end
    end
  end

  // Registered bank reads; same-cycle write to the same address returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_BANK; k++) begin
        rd_r[k] <= {DATA_BIT{1'b0}};
      end
    end else if (bus.en && bus.re) begin
      for (int k = 0; k < NUM_BANK; k++) begin
        rd_r[k] <= bank_r[k][bus.addr_read[k*ADDR_BIT +: ADDR_BIT]];
      end
    end
  end

  // Operand selection for the two butterflies.
  always_comb begin
    x0_s = rd_r[0];
    x1_s = rd_r[1];
    x2_s = rd_r[2];
    x3_s = rd_r[3];

    if (bus.m11) begin
      x0_s = rd_r[1];
    end else begin
      x0_s = rd_r[0];
    end

    case (bus.m12)
      2'd0:    x1_s = rd_r[0];
      2'd1:    x1_s = rd_r[1];
      2'd2:    x1_s = rd_r[2];
      2'd3:    x1_s = rd_r[3];
      default: x1_s = rd_r[1];
    endcase

    // Note the bank order for x2 lists bank 2 before bank 1.
    case (bus.m13)
      2'd0:    x2_s = rd_r[0];
      2'd1:    x2_s = rd_r[2];
      2'd2:    x2_s = rd_r[1];
      2'd3:    x2_s = rd_r[3];
      default: x2_s = rd_r[2];
    endcase

    if (bus.m14) begin
      x3_s = rd_r[3];
    end else begin
      x3_s = rd_r[2];
    end
  end

  rfft_bfly u_bfly_a (
    .a         (x0_s),
    .b         (x1_s),
    .w_r       (bus.w_r),
    .w_i       (bus.w_i),
    .bypass_en (bus.bypass_en),
    .y_sum     (y0_s),
    .y_diff    (y1_s)
  );

  rfft_bfly u_bfly_b (
    .a         (x2_s),
    .b         (x3_s),
    .w_r       (bus.w_r),
    .w_i       (bus.w_i),
    .bypass_en (bus.bypass_en),
    .y_sum     (y2_s),
    .y_diff    (y3_s)
  );

  // Write-data routing; load mode bypasses the butterflies entirely.
  always_comb begin
    for (int k = 0; k < NUM_BANK; k++) begin
      wr_s[k] = load_s[k];
    end
    if (bus.m0) begin
      wr_s[0] = bus.m21 ? y2_s : y0_s;
      wr_s[1] = bus.m22 ? y3_s : y1_s;
      wr_s[2] = bus.m23 ? y2_s : y0_s;
      wr_s[3] = bus.m24 ? y3_s : y1_s;
    end else begin
      for (int k = 0; k < NUM_BANK; k++) begin
        wr_s[k] = load_s[k];
      end
    end
  end

endmodule

// File: tb/tb_rfft_4pt256.sv
// Directed bench for rfft_4pt256: load/readback, butterfly arithmetic,
// twiddle multiply, routing, wrap-around and asynchronous reset.
module tb_rfft_4pt256;
  import rfft_4pt256_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rfft_4pt256_if bus ();

  rfft_4pt256 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [23:0] addr4(input logic [5:0] a3, input logic [5:0] a2,
                                        input logic [5:0] a1, input logic [5:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic set_in(input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [15:0] v3);
    bus.in0 = v0; bus.in1 = v1; bus.in2 = v2; bus.in3 = v3;
  endtask

  task automatic set_route(input logic r1, input logic r2, input logic r3, input logic r4);
    bus.m21 = r1; bus.m22 = r2; bus.m23 = r3; bus.m24 = r4;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_in(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    bus.m0 = 1'b0; bus.m11 = 1'b0; bus.m12 = 2'd1; bus.m13 = 2'd1; bus.m14 = 1'b1;
    set_route(1'b0, 1'b0, 1'b1, 1'b1);
    bus.en = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
    bus.w_r = TW_ONE; bus.w_i = 16'h0000; bus.bypass_en = 1'b1;
    bus.addr_read = 24'h000000; bus.addr_write = 24'h000000;

    // Reset state
    #1;
    check("reset_mem0", bus.mem0, 16'h0000);
    check("reset_mem3", bus.mem3, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Load four distinct words at address 5; load override passes in_k through
    bus.en = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.m0 = 1'b0;
    set_in(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    bus.addr_write = addr4(6'd5, 6'd5, 6'd5, 6'd5);
    #1;
    check("load_pass_mem0_i", bus.mem0_i, 16'h0102);
    check("load_pass_mem3_i", bus.mem3_i, 16'h0708);
    tick();
    bus.we = 1'b0; bus.re = 1'b1;
    bus.addr_read = addr4(6'd5, 6'd5, 6'd5, 6'd5);
    tick();
    check("readback_mem0", bus.mem0, 16'h0102);
    check("readback_mem1", bus.mem1, 16'h0304);
    check("readback_mem2", bus.mem2, 16'h0506);
    check("readback_mem3", bus.mem3, 16'h0708);

    // Same-address read and write in one cycle returns old data
    bus.we = 1'b1;
    set_in(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick();
    check("rw_same_old", bus.mem0, 16'h0102);
    bus.we = 1'b0;
    tick();
    check("rw_same_new", bus.mem0, 16'h1111);

    // en low: read register holds even with re high and a new address
    bus.en = 1'b0;
    bus.addr_read = addr4(6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    check("en_low_hold", bus.mem1, 16'h2222);
    bus.en = 1'b1;

    // Load butterfly operands at address 0 and 1
    bus.we = 1'b1; bus.re = 1'b0;
    bus.addr_write = addr4(6'd0, 6'd0, 6'd0, 6'd0);
    set_in(16'h0300, 16'h0100, 16'h0500, 16'h0100);
    tick();
    bus.addr_write = addr4(6'd1, 6'd1, 6'd1, 6'd1);
    set_in(16'h7F00, 16'h0100, 16'h0100, 16'h0000);
    tick();
    bus.we = 1'b0; bus.re = 1'b1;
    bus.addr_read = addr4(6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    bus.re = 1'b0;

    // Bypass butterfly, straight routing
    bus.m0 = 1'b1; bus.bypass_en = 1'b1;
    set_route(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("byp_mem0_i", bus.mem0_i, 16'h0400);
    check("byp_mem1_i", bus.mem1_i, 16'h0200);
    check("byp_mem2_i", bus.mem2_i, 16'h0600);
    check("byp_mem3_i", bus.mem3_i, 16'h0400);

    // Twiddle 1.0 leaves the difference unchanged
    bus.bypass_en = 1'b0; bus.w_r = TW_ONE; bus.w_i = 16'h0000;
    #1;
    check("tw_one_mem1_i", bus.mem1_i, 16'h0200);

    // Twiddle -j: (2,0) -> (0,-2), (4,0) -> (0,-4)
    bus.w_r = 16'h0000; bus.w_i = 16'hC000;
    #1;
    check("tw_mj_mem1_i", bus.mem1_i, 16'h00FE);
    check("tw_mj_mem0_i", bus.mem0_i, 16'h0400);
    check("tw_mj_mem3_i", bus.mem3_i, 16'h00FC);

    // Swapped routing with bypass
    bus.bypass_en = 1'b1;
    set_route(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("swap_mem0_i", bus.mem0_i, 16'h0600);
    check("swap_mem1_i", bus.mem1_i, 16'h0400);
    check("swap_mem2_i", bus.mem2_i, 16'h0400);
    check("swap_mem3_i", bus.mem3_i, 16'h0200);

    // Operand mux: x0=mem1, x1=mem3 -> 0x0100+0x0100
    set_route(1'b0, 1'b0, 1'b1, 1'b1);
    bus.m11 = 1'b1; bus.m12 = 2'd3;
    #1;
    check("mux_mem0_i", bus.mem0_i, 16'h0200);
    bus.m11 = 1'b0; bus.m12 = 2'd1;

    // Wrap arithmetic on address 1 operands
    bus.re = 1'b1;
    bus.addr_read = addr4(6'd1, 6'd1, 6'd1, 6'd1);
    tick();
    bus.re = 1'b0;
    #1;
    check("wrap_mem0_i", bus.mem0_i, 16'h8000);
    check("wrap_diff_mem1_i", bus.mem1_i, 16'h7E00);

    // Twiddle -0.5: floor on the shift, (1,0) -> (-1,0), (126,0) -> (-63,0)
    bus.bypass_en = 1'b0; bus.w_r = 16'hE000; bus.w_i = 16'h0000;
    #1;
    check("floor_mem3_i", bus.mem3_i, 16'hFF00);
    check("half_mem1_i", bus.mem1_i, 16'hC100);

    // Asynchronous reset between edges clears read registers at once
    check("pre_rst_mem0", bus.mem0, 16'h7F00);
    bus.re = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mem0", bus.mem0, 16'h0000);
    check("rst_async_mem1", bus.mem1, 16'h0000);
    tick();
    check("rst_hold_mem0", bus.mem0, 16'h0000);
    rst = 1'b0;
    tick();
    check("post_rst_mem0", bus.mem0, 16'h7F00);
    check("post_rst_mem1", bus.mem1, 16'h0100);
    bus.addr_read = addr4(6'd5, 6'd5, 6'd5, 6'd5);
    tick();
    check("post_rst_addr5", bus.mem3, 16'h4444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
